// File: rtl/router_port_reader.sv
// ----------------------------------------------------------------------------
// router_port_reader
//   Destination-side consumer for one router output port. Waits READ_DELAY
//   cycles after the port FIFO becomes non-empty, drains one packet
//   (header {len[7:2],addr[1:0]}, len payload bytes, parity byte), checks the
//   address against PORT_ADDR and the XOR parity, then reports the result.
//   A router soft reset on this port aborts the packet in progress.
//
// Optional build macro:
//   ROUTER_RD_STALL_EN  adds an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5)
//                       whose bit 0 inserts random read back-pressure in BODY.
//
// Ports:
//   clk        in   clock, rising edge
//   resetn     in   synchronous active-low reset
//   vld_out    in   port FIFO not empty
//   data_out   in   FIFO read data, valid the cycle after an issued read
//   soft_reset in   router soft reset for this port (FIFO flushed)
//   read_enb   out  FIFO read strobe (combinational)
//   busy       out  high in any state but IDLE
//   pkt_done   out  1-cycle pulse when a packet finishes (good, bad or aborted)
//   pkt_err    out  1-cycle pulse with pkt_done when err_code != 0
//   err_code   out  00 ok, 01 parity, 10 addr mismatch, 11 aborted
//   pkt_len    out  payload length of the last completed packet
//   pkt_cnt    out  good packets, saturating
//   err_cnt    out  bad or aborted packets, saturating
// ----------------------------------------------------------------------------
module router_port_reader #(
    parameter int unsigned PORT_ADDR  = 0,
    parameter int unsigned READ_DELAY = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             vld_out,
    input  logic [7:0]       data_out,
    input  logic             soft_reset,
    output logic             read_enb,
    output logic             busy,
    output logic             pkt_done,
    output logic             pkt_err,
    output logic [1:0]       err_code,
    output logic [5:0]       pkt_len,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [1:0] ADDR   = PORT_ADDR[1:0];
    localparam logic [5:0] RD_DLY = READ_DELAY[5:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_HDR_RD,
        S_HDR_CAP,
        S_BODY,
        S_CHECK
    } state_t;

    state_t           state_q;
    logic [5:0]       dly_q;
    logic [7:0]       hdr_q;
    logic [7:0]       par_q;
    logic [6:0]       rem_q;      // reads still to issue (payload + parity)
    logic [6:0]       cap_q;      // bytes still to capture
    logic             rd_q;       // a read was issued last cycle
    logic             pkt_done_q;
    logic             pkt_err_q;
    logic [1:0]       err_code_q;
    logic [5:0]       pkt_len_q;
    logic [CNT_W-1:0] pkt_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic             stall_ok;
    logic [7:0]       par_d;
    logic [1:0]       err_code_d;

`ifdef ROUTER_RD_STALL_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign stall_ok = !lfsr_q[0];
`else
    assign stall_ok = 1'b1;
`endif

    // Read strobe is combinational so a read can be issued every BODY cycle.
    always_comb begin
        read_enb = 1'b0;
        if (!soft_reset) begin
            case (state_q)
                S_HDR_RD: read_enb = vld_out;
                S_BODY:   read_enb = vld_out && (rem_q != '0) && stall_ok;
                default:  read_enb = 1'b0;
            endcase
        end
    end

    // Final parity includes the byte being captured this cycle, so the
    // verdict is registered on the same edge that enters CHECK and is
    // visible during the CHECK cycle.
    always_comb begin
        par_d = par_q ^ data_out;
        if (hdr_q[1:0] != ADDR) begin
            err_code_d = 2'b10;
        end else if (par_d != '0) begin
            err_code_d = 2'b01;
        end else begin
            err_code_d = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            dly_q      <= '0;
            hdr_q      <= '0;
            par_q      <= '0;
            rem_q      <= '0;
            cap_q      <= '0;
            rd_q       <= 1'b0;
            pkt_done_q <= 1'b0;
            pkt_err_q  <= 1'b0;
            err_code_q <= '0;
            pkt_len_q  <= '0;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            pkt_done_q <= 1'b0;
            pkt_err_q  <= 1'b0;
            rd_q       <= read_enb;
            if (soft_reset && (state_q != S_IDLE)) begin
                state_q    <= S_IDLE;
                pkt_done_q <= 1'b1;
                pkt_err_q  <= 1'b1;
                err_code_q <= 2'b11;
                if (err_cnt_q != '1) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (vld_out) begin
                            state_q <= S_WAIT;
                            dly_q   <= '0;
                        end
                    end
                    S_WAIT: begin
                        if (dly_q == RD_DLY) begin
                            state_q <= S_HDR_RD;
                        end else begin
                            dly_q <= dly_q + 1'b1;
                        end
                    end
                    S_HDR_RD: begin
                        if (read_enb) begin
                            state_q <= S_HDR_CAP;
                        end
                    end
                    S_HDR_CAP: begin
                        hdr_q   <= data_out;
                        par_q   <= data_out;
                        rem_q   <= {1'b0, data_out[7:2]} + 7'd1;
                        cap_q   <= {1'b0, data_out[7:2]} + 7'd1;
                        state_q <= S_BODY;
                    end
                    S_BODY: begin
                        if (read_enb) begin
                            rem_q <= rem_q - 1'b1;
                        end
                        if (rd_q) begin
                            par_q <= par_d;
                            cap_q <= cap_q - 1'b1;
                            if (cap_q == 7'd1) begin
                                state_q    <= S_CHECK;
                                pkt_done_q <= 1'b1;
                                pkt_err_q  <= (err_code_d != 2'b00);
                                err_code_q <= err_code_d;
                                pkt_len_q  <= hdr_q[7:2];
                                if (err_code_d == 2'b00) begin
                                    if (pkt_cnt_q != '1) begin
                                        pkt_cnt_q <= pkt_cnt_q + 1'b1;
                                    end
                                end else if (err_cnt_q != '1) begin
                                    err_cnt_q <= err_cnt_q + 1'b1;
                                end
                            end
                        end
                    end
                    S_CHECK: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign pkt_done = pkt_done_q;
    assign pkt_err  = pkt_err_q;
    assign err_code = err_code_q;
    assign pkt_len  = pkt_len_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_router_port_reader.sv
// ----------------------------------------------------------------------------
// tb_router_port_reader
//   Three reader instances share one model port FIFO; sel picks which one
//   sees vld_out and drives the pop. Instance A: PORT_ADDR=0, READ_DELAY=2.
//   Instance B: PORT_ADDR=2, READ_DELAY=0. Instance C: READ_DELAY=40 for the
//   soft-reset timeout case. soft_reset is shared, so A and B also see it
//   while idle.
// ----------------------------------------------------------------------------
module tb_router_port_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn     = 1'b0;
    logic       soft_reset = 1'b0;
    logic       hold       = 1'b0;
    logic [1:0] sel        = 2'd0;

    logic [7:0] mem [0:63];
    logic [5:0] wr   = '0;
    logic [5:0] rd   = '0;
    logic [7:0] dout = '0;
    logic       vld;

    logic        re_a, busy_a, done_a, err_a;
    logic [1:0]  code_a;
    logic [5:0]  len_a;
    logic [15:0] pcnt_a, ecnt_a;
    logic        re_b, busy_b, done_b, err_b;
    logic [1:0]  code_b;
    logic [5:0]  len_b;
    logic [15:0] pcnt_b, ecnt_b;
    logic        re_c, busy_c, done_c, err_c;
    logic [1:0]  code_c;
    logic [5:0]  len_c;
    logic [15:0] pcnt_c, ecnt_c;

    logic vld_a, vld_b, vld_c, rd_sel, done_sel;

    assign vld      = (wr != rd) && !hold;
    assign vld_a    = vld && (sel == 2'd0);
    assign vld_b    = vld && (sel == 2'd1);
    assign vld_c    = vld && (sel == 2'd2);
    assign rd_sel   = (sel == 2'd0) ? re_a : (sel == 2'd1) ? re_b : re_c;
    assign done_sel = (sel == 2'd0) ? done_a : (sel == 2'd1) ? done_b : done_c;

    // Model port FIFO: data appears the cycle after a read; flushed on reset
    // or soft reset.
    always @(posedge clk) begin
        if (!resetn || soft_reset) begin
            rd <= wr;
        end else if (rd_sel && vld) begin
            dout <= mem[rd];
            rd   <= rd + 6'd1;
        end
    end

    router_port_reader #(.PORT_ADDR(0), .READ_DELAY(2), .CNT_W(16)) dut_a (
        .clk(clk), .resetn(resetn), .vld_out(vld_a), .data_out(dout),
        .soft_reset(soft_reset), .read_enb(re_a), .busy(busy_a),
        .pkt_done(done_a), .pkt_err(err_a), .err_code(code_a),
        .pkt_len(len_a), .pkt_cnt(pcnt_a), .err_cnt(ecnt_a)
    );

    router_port_reader #(.PORT_ADDR(2), .READ_DELAY(0), .CNT_W(16)) dut_b (
        .clk(clk), .resetn(resetn), .vld_out(vld_b), .data_out(dout),
        .soft_reset(soft_reset), .read_enb(re_b), .busy(busy_b),
        .pkt_done(done_b), .pkt_err(err_b), .err_code(code_b),
        .pkt_len(len_b), .pkt_cnt(pcnt_b), .err_cnt(ecnt_b)
    );

    router_port_reader #(.PORT_ADDR(0), .READ_DELAY(40), .CNT_W(16)) dut_c (
        .clk(clk), .resetn(resetn), .vld_out(vld_c), .data_out(dout),
        .soft_reset(soft_reset), .read_enb(re_c), .busy(busy_c),
        .pkt_done(done_c), .pkt_err(err_c), .err_code(code_c),
        .pkt_len(len_c), .pkt_cnt(pcnt_c), .err_cnt(ecnt_c)
    );

    int vectors = 0;
    int fails   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr] = b;
        wr      = wr + 6'd1;
    endtask

    // wcnt: cycles from call to first read; lat: first read to pkt_done;
    // nrd: reads issued up to pkt_done. All bounded.
    task automatic run_pkt(output int wcnt, output int lat, output int nrd);
        int g;
        wcnt = 0; lat = 0; nrd = 0; g = 0;
        while (!(rd_sel && vld) && g < 100) begin
            cyc(); wcnt++; g++;
        end
        nrd = (rd_sel && vld) ? 1 : 0;
        while (!done_sel && g < 200) begin
            cyc(); lat++; g++;
            if (rd_sel && vld) nrd++;
        end
    endtask

    int  wcnt, lat, nrd, g;
    bit  any_rd;

    initial begin
        // ---------------- reset ----------------
        repeat (3) cyc();
        chk("rst_re_a", re_a, 0);      chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", done_a, 0);  chk("rst_err_a", err_a, 0);
        chk("rst_code_a", code_a, 0);  chk("rst_len_a", len_a, 0);
        chk("rst_pcnt_a", pcnt_a, 0);  chk("rst_ecnt_a", ecnt_a, 0);
        chk("rst_re_b", re_b, 0);      chk("rst_busy_b", busy_b, 0);
        chk("rst_done_b", done_b, 0);  chk("rst_err_b", err_b, 0);
        chk("rst_code_b", code_b, 0);  chk("rst_len_b", len_b, 0);
        chk("rst_pcnt_b", pcnt_b, 0);  chk("rst_ecnt_b", ecnt_b, 0);
        chk("rst_re_c", re_c, 0);      chk("rst_busy_c", busy_c, 0);
        chk("rst_done_c", done_c, 0);  chk("rst_err_c", err_c, 0);
        chk("rst_code_c", code_c, 0);  chk("rst_len_c", len_c, 0);
        chk("rst_pcnt_c", pcnt_c, 0);  chk("rst_ecnt_c", ecnt_c, 0);
        resetn = 1'b1;
        cyc();

        // ---------------- 1: good packet on A ----------------
        sel = 2'd0;
        push(8'h0C); push(8'h11); push(8'h22); push(8'h33); push(8'h0C);
        run_pkt(wcnt, lat, nrd);
        chk("t1_wait", wcnt, 4);
        chk("t1_lat", lat, 7);
        chk("t1_reads", nrd, 5);
        chk("t1_done", done_a, 1);
        chk("t1_busy", busy_a, 1);
        chk("t1_err", err_a, 0);
        chk("t1_code", code_a, 0);
        chk("t1_len", len_a, 3);
        chk("t1_pcnt", pcnt_a, 1);
        chk("t1_ecnt", ecnt_a, 0);
        cyc();
        chk("t1_done_pulse", done_a, 0);
        chk("t1_idle", busy_a, 0);

        // ---------------- 2: bad parity ----------------
        push(8'h0C); push(8'h11); push(8'h22); push(8'h33); push(8'h0D);
        run_pkt(wcnt, lat, nrd);
        chk("t2_lat", lat, 7);
        chk("t2_done", done_a, 1);
        chk("t2_err", err_a, 1);
        chk("t2_code", code_a, 1);
        chk("t2_ecnt", ecnt_a, 1);
        chk("t2_pcnt", pcnt_a, 1);
        cyc();
        chk("t2_err_pulse", err_a, 0);

        // ---------------- 3: addr mismatch (parity also bad: addr wins) ----------------
        push(8'h05); push(8'hAA); push(8'h00);
        run_pkt(wcnt, lat, nrd);
        chk("t3_reads", nrd, 3);
        chk("t3_lat", lat, 5);
        chk("t3_err", err_a, 1);
        chk("t3_code", code_a, 2);
        chk("t3_len", len_a, 1);
        chk("t3_ecnt", ecnt_a, 2);
        chk("t3_pcnt", pcnt_a, 1);
        cyc();
        chk("t3_drained", vld_a, 0);

        // ---------------- 5: mid-packet stall of 5 cycles ----------------
        push(8'h0C); push(8'h11); push(8'h22); push(8'h33); push(8'h0C);
        g = 0;
        while (!(rd_sel && vld) && g < 100) begin cyc(); g++; end
        lat = 0; nrd = 1;
        while (nrd < 3 && g < 200) begin
            cyc(); lat++; g++;
            if (rd_sel && vld) nrd++;
        end
        cyc(); lat++;
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t5_stall_re", re_a, 0);
            cyc(); lat++;
        end
        hold = 1'b0;
        while (!done_a && g < 300) begin cyc(); lat++; g++; end
        chk("t5_lat", lat, 12);
        chk("t5_code", code_a, 0);
        chk("t5_err", err_a, 0);
        chk("t5_pcnt", pcnt_a, 2);
        chk("t5_len", len_a, 3);
        cyc();

        // ---------------- soft reset mid-body on A ----------------
        push(8'h0C); push(8'h11); push(8'h22); push(8'h33); push(8'h0C);
        g = 0;
        while (!(rd_sel && vld) && g < 100) begin cyc(); g++; end
        repeat (3) cyc();
        soft_reset = 1'b1;
        #1;
        chk("ab_vld", vld_a, 1);
        chk("ab_re_forced", re_a, 0);
        cyc();
        soft_reset = 1'b0;
        chk("ab_done", done_a, 1);
        chk("ab_err", err_a, 1);
        chk("ab_code", code_a, 3);
        chk("ab_ecnt", ecnt_a, 3);
        chk("ab_pcnt", pcnt_a, 2);
        chk("ab_idle", busy_a, 0);
        chk("ab_flushed", vld_a, 0);
        cyc();
        chk("ab_done_pulse", done_a, 0);

        // ---------------- 6: len=0 on B (PORT_ADDR=2, READ_DELAY=0) ----------------
        sel = 2'd1;
        push(8'h02); push(8'h02);
        run_pkt(wcnt, lat, nrd);
        chk("t6_wait", wcnt, 2);
        chk("t6_lat", lat, 4);
        chk("t6_reads", nrd, 2);
        chk("t6_done", done_b, 1);
        chk("t6_code", code_b, 0);
        chk("t6_len", len_b, 0);
        chk("t6_pcnt", pcnt_b, 1);
        chk("t6_ecnt", ecnt_b, 0);
        cyc();

        // ---------------- 4: timeout on C (READ_DELAY=40) ----------------
        sel = 2'd2;
        push(8'h0C);
        any_rd = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (re_c) any_rd = 1'b1;
        end
        chk("t4_no_read", any_rd, 0);
        chk("t4_busy_wait", busy_c, 1);
        soft_reset = 1'b1;
        cyc();
        soft_reset = 1'b0;
        chk("t4_done", done_c, 1);
        chk("t4_err", err_c, 1);
        chk("t4_code", code_c, 3);
        chk("t4_ecnt", ecnt_c, 1);
        chk("t4_idle", busy_c, 0);
        chk("t4_a_idle_ignored", ecnt_a, 3);
        chk("t4_a_no_done", done_a, 0);
        chk("t4_b_idle_ignored", ecnt_b, 0);
        cyc();

        // ---------------- resetn mid-packet on A ----------------
        sel = 2'd0;
        push(8'h0C); push(8'h11); push(8'h22); push(8'h33); push(8'h0C);
        g = 0;
        while (!(rd_sel && vld) && g < 100) begin cyc(); g++; end
        repeat (3) cyc();
        chk("mr_busy_before", busy_a, 1);
        resetn = 1'b0;
        cyc();
        chk("mr_busy", busy_a, 0);
        chk("mr_re", re_a, 0);
        chk("mr_code", code_a, 0);
        chk("mr_len", len_a, 0);
        chk("mr_pcnt", pcnt_a, 0);
        chk("mr_ecnt", ecnt_a, 0);
        resetn = 1'b1;
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
